// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Command-side initiator for the 4-bit-operand / 8-bit-result combinational
//   ALU. Commands {op, a, b} arrive on a valid/ready stream and are buffered in
//   a DEPTH-entry FIFO. One command at a time is presented to the ALU for a
//   single cycle (alu_en), the ALU output is captured, and the result is
//   returned in order on a valid/ready result stream.
//
//   Parameters
//     DEPTH  command FIFO entries (power of 2, >= 2)
//     CNT_W  width of the completed-operation counter (wraps)
//
//   Ports
//     clk, rst                       clock, synchronous active-high reset
//     cmd_valid/cmd_ready            command handshake; cmd_ready = FIFO not full
//     cmd_op, cmd_a, cmd_b           command payload
//     alu_a, alu_b, alu_op, alu_en   registered ALU inputs, one-cycle strobe
//     alu_out                        combinational ALU result
//     res_valid/res_ready            result handshake
//     res_data, res_op, res_err      captured result, its opcode, error flag
//     busy                           FSM not idle or FIFO not empty
//     done_cnt                       count of results handed off
//
//   Build option
//     ALU_SEQ_DIVZERO_CHK_EN  when defined, div/mod by zero captures 8'hFF and
//                             raises res_err; otherwise res_err is tied low and
//                             res_data is the raw ALU output.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_en,
  input  logic [7:0]       alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [3:0]       res_op,
  output logic             res_err,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  // FIFO storage and pointers; the extra MSB on each pointer distinguishes
  // full from empty when the index bits match.
  logic [11:0] fifo_mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_full, fifo_empty;
  logic        push, pop;
  logic [11:0] head;
  logic [7:0]  cap_data;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Push is gated only by full: a pop in the same cycle does not open a slot.
  assign cmd_ready = ~fifo_full;
  assign push      = cmd_valid & ~fifo_full;
  assign pop       = (state == IDLE) & ~fifo_empty;
  assign head      = fifo_mem[rd_ptr[AW-1:0]];
  assign busy      = (state != IDLE) | ~fifo_empty;

`ifdef ALU_SEQ_DIVZERO_CHK_EN
  logic cap_err;
  logic err_q;

  // Division and modulo by zero are still issued; only the capture is replaced.
  assign cap_err  = ((alu_op == 4'd3) || (alu_op == 4'd4)) && (alu_b == 4'd0);
  assign cap_data = cap_err ? 8'hFF : alu_out;
  assign res_err  = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == EXEC) begin
      err_q <= cap_err;
    end
  end
`else
  assign cap_data = alu_out;
  assign res_err  = 1'b0;
`endif

  // FIFO storage write (data only, no reset)
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_a, cmd_b};
    end
  end

  // FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue stage: head of FIFO -> ALU inputs; capture stage: ALU -> result
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_en    <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
      done_cnt  <= '0;
    end else begin
      if (pop) begin
        alu_op <= head[11:8];
        alu_a  <= head[7:4];
        alu_b  <= head[3:0];
        alu_en <= 1'b1;
      end
      if (state == EXEC) begin
        alu_en    <= 1'b0;
        res_data  <= cap_data;
        res_op    <= alu_op;
        res_valid <= 1'b1;
      end
      if ((state == RESP) && res_ready) begin
        res_valid <= 1'b0;
        done_cnt  <= done_cnt + CNT_ONE;
      end
    end
  end

endmodule
